// File: rtl/cp_dmem_dma_if.sv
// Control, stream and data-memory bus signals of the word-streaming DMA engine.
// master = DMA engine side, slave = host / stream partners / memory side.
`ifndef DEF_CP_DATA_WIDTH
`define DEF_CP_DATA_WIDTH 32
`endif
`ifndef DEF_CP_D_MEM_ADDR_WIDTH
`define DEF_CP_D_MEM_ADDR_WIDTH 32
`endif

interface cp_dmem_dma_if #(
    parameter int DATA_WIDTH = `DEF_CP_DATA_WIDTH,
    parameter int ADDR_WIDTH = `DEF_CP_D_MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = 16
);
    logic                  iStart;
    logic                  iDirection;
    logic [ADDR_WIDTH-1:0] iBase_Address;
    logic [LEN_WIDTH-1:0]  iLength;
    logic                  oBusy;
    logic                  oDone;
    logic                  iIn_Valid;
    logic [DATA_WIDTH-1:0] iIn_Data;
    logic                  oIn_Ready;
    logic                  oOut_Valid;
    logic [DATA_WIDTH-1:0] oOut_Data;
    logic                  iOut_Ready;
    logic                  oBus_Valid;
    logic [ADDR_WIDTH-1:0] oBus_Address;
    logic [DATA_WIDTH-1:0] oBus_Write_Data;
    logic                  oBus_Write_Enable;
    logic [DATA_WIDTH-1:0] iBus_Read_Data;

    modport master (
        input  iStart, iDirection, iBase_Address, iLength,
        input  iIn_Valid, iIn_Data, iOut_Ready, iBus_Read_Data,
        output oBusy, oDone, oIn_Ready, oOut_Valid, oOut_Data,
        output oBus_Valid, oBus_Address, oBus_Write_Data, oBus_Write_Enable
    );

    modport slave (
        output iStart, iDirection, iBase_Address, iLength,
        output iIn_Valid, iIn_Data, iOut_Ready, iBus_Read_Data,
        input  oBusy, oDone, oIn_Ready, oOut_Valid, oOut_Data,
        input  oBus_Valid, oBus_Address, oBus_Write_Data, oBus_Write_Enable
    );
endinterface

// File: rtl/cp_dmem_dma.sv
// Word-streaming DMA between valid/ready streams and data-memory port A; bus outputs registered, 1 word/cycle.
// Reads are credit-limited to 2 words outstanding plus buffered so output backpressure never loses data.
`ifndef DEF_CP_DATA_WIDTH
`define DEF_CP_DATA_WIDTH 32
`endif
`ifndef DEF_CP_D_MEM_ADDR_WIDTH
`define DEF_CP_D_MEM_ADDR_WIDTH 32
`endif

module cp_dmem_dma #(
    parameter int DATA_WIDTH = `DEF_CP_DATA_WIDTH,
    parameter int ADDR_WIDTH = `DEF_CP_D_MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = 16
) (
    input logic           iClk,
    input logic           iReset_N,
    cp_dmem_dma_if.master dma
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  busValid;
    logic                  busWe;
    logic [ADDR_WIDTH-1:0] busAddr;
    logic [DATA_WIDTH-1:0] busWData;
    logic                  busy;
    logic                  done;
    logic                  rdReturn;
    logic [DATA_WIDTH-1:0] fifoMem [2];
    logic                  rdPtr;
    logic                  wrPtr;
    logic [1:0]            fifoCount;

    logic       inReady, inHs, outValid, outHs, busRd, fifoEmpty, fifoPush, fifoPop;
    logic       issueRd, readFinished;
    logic [2:0] pending, pendingAfter;

    assign inReady   = (state == WRITE) && (remaining != '0);
    assign inHs      = dma.iIn_Valid && inReady;
    assign busRd     = busValid && !busWe;
    assign fifoEmpty = (fifoCount == 2'd0);
    assign outValid  = (state == READ) && (!fifoEmpty || rdReturn);
    assign outHs     = outValid && dma.iOut_Ready;
    // Returning read data falls through to the output when the FIFO is empty.
    assign fifoPush  = rdReturn && !(fifoEmpty && outHs);
    assign fifoPop   = outHs && !fifoEmpty;

    // Every word issued but not yet delivered holds one of two credits.
    assign pending      = {1'b0, fifoCount} + {2'b0, busRd} + {2'b0, rdReturn};
    assign pendingAfter = pending - {2'b0, outHs};
    assign issueRd      = (state == READ) && (remaining != '0) && (pendingAfter < 3'd2);
    assign readFinished = (state == READ) && (remaining == '0) && (pendingAfter == 3'd0);

    always_ff @(posedge iClk or negedge iReset_N) begin
        if (!iReset_N) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            busValid   <= 1'b0;
            busWe      <= 1'b0;
            busAddr    <= '0;
            busWData   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdReturn   <= 1'b0;
            fifoMem[0] <= '0;
            fifoMem[1] <= '0;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
            fifoCount  <= 2'd0;
        end else begin
            done     <= 1'b0;
            busValid <= 1'b0;
            busWe    <= 1'b0;
            rdReturn <= busRd;
            if (fifoPush) begin
                fifoMem[wrPtr] <= dma.iBus_Read_Data;
                wrPtr          <= ~wrPtr;
            end
            if (fifoPop) rdPtr <= ~rdPtr;
            fifoCount <= fifoCount + {1'b0, fifoPush} - {1'b0, fifoPop};

            unique case (state)
                IDLE: begin
                    if (dma.iStart) begin
                        if (dma.iLength != '0) begin
                            addr      <= {dma.iBase_Address[ADDR_WIDTH-1:2], 2'b00};
                            remaining <= dma.iLength;
                            busy      <= 1'b1;
                            state     <= dma.iDirection ? READ : WRITE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (inHs) begin
                        busValid  <= 1'b1;
                        busWe     <= 1'b1;
                        busAddr   <= addr;
                        busWData  <= dma.iIn_Data;
                        addr      <= addr + ADDR_WIDTH'(4);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end else if (remaining == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                READ: begin
                    if (issueRd) begin
                        busValid  <= 1'b1;
                        busAddr   <= addr;
                        addr      <= addr + ADDR_WIDTH'(4);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                    if (readFinished) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dma.oBusy             = busy;
    assign dma.oDone             = done;
    assign dma.oIn_Ready         = inReady;
    assign dma.oOut_Valid        = outValid;
    assign dma.oOut_Data         = !fifoEmpty ? fifoMem[rdPtr] : (rdReturn ? dma.iBus_Read_Data : '0);
    assign dma.oBus_Valid        = busValid;
    assign dma.oBus_Address      = busAddr;
    assign dma.oBus_Write_Data   = busWData;
    assign dma.oBus_Write_Enable = busWe;
endmodule

// File: tb/tb_cp_dmem_dma.sv
// Scoreboard bench for cp_dmem_dma: stimulus pushes expected bus/stream/done events, a monitor pops them.
// A 64-word memory model with 1-cycle read latency sits on the bus port.
module tb_cp_dmem_dma;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        int          cyc;
    } busExp_t;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } outExp_t;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFail = 0;
    int   doneCnt = 0;
    int   doneBase = 0;
    int   rdIss = 0;
    int   hsCnt = 0;
    int   readyMode = 0;
    logic [31:0] mem [64];

    busExp_t busQ[$];
    outExp_t outQ[$];
    int      doneQ[$];
    busExp_t mb;
    outExp_t mo;
    int      md;

    cp_dmem_dma_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dif ();

    cp_dmem_dma #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .iClk    (clk),
        .iReset_N(rstN),
        .dma     (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void pushBus(input logic [31:0] a, input logic we, input logic [31:0] d, input int c);
        busExp_t e;
        e.addr = a; e.we = we; e.data = d; e.cyc = c;
        busQ.push_back(e);
    endfunction

    function automatic void pushOut(input logic [31:0] d, input int c);
        outExp_t e;
        e.data = d; e.cyc = c;
        outQ.push_back(e);
    endfunction

    // Memory model: 1-cycle read latency, index by word address bits [7:2].
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 + 32'(i);
        dif.iBus_Read_Data = '0;
        forever begin
            @(posedge clk);
            if (dif.oBus_Valid) begin
                if (dif.oBus_Write_Enable) mem[dif.oBus_Address[7:2]] <= dif.oBus_Write_Data;
                else dif.iBus_Read_Data <= mem[dif.oBus_Address[7:2]];
            end
        end
    end

    initial begin
        dif.iOut_Ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       dif.iOut_Ready = 1'b1;
                1:       dif.iOut_Ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: dif.iOut_Ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstN) begin
                rdIss = 0;
                hsCnt = 0;
            end else begin
                if (dif.oBus_Valid) begin
                    if (!dif.oBus_Write_Enable) rdIss++;
                    if (busQ.size() == 0) check("bus_unexpected", dif.oBus_Valid, 0);
                    else begin
                        mb = busQ.pop_front();
                        check("bus_addr", dif.oBus_Address, mb.addr);
                        check("bus_we", dif.oBus_Write_Enable, mb.we);
                        if (mb.we) check("bus_wdata", dif.oBus_Write_Data, mb.data);
                        if (mb.cyc >= 0) check("bus_cycle", 64'(cyc), 64'(mb.cyc));
                    end
                end
                if (dif.oBusy) check("outstanding_le2", 64'((rdIss - hsCnt) <= 2), 1);
                if (dif.oOut_Valid && dif.iOut_Ready) begin
                    hsCnt++;
                    if (outQ.size() == 0) check("out_unexpected", dif.oOut_Valid, 0);
                    else begin
                        mo = outQ.pop_front();
                        check("out_data", dif.oOut_Data, mo.data);
                        if (mo.cyc >= 0) check("out_cycle", 64'(cyc), 64'(mo.cyc));
                    end
                end
                if (dif.oDone) begin
                    doneCnt++;
                    check("done_busy_low", dif.oBusy, 0);
                    if (doneQ.size() == 0) check("done_unexpected", dif.oDone, 0);
                    else begin
                        md = doneQ.pop_front();
                        if (md >= 0) check("done_cycle", 64'(cyc), 64'(md));
                    end
                end
            end
        end
    end

    task automatic startXfer(input logic dir, input logic [31:0] base, input logic [15:0] len, output int k);
        @(posedge clk);
        #1;
        dif.iStart = 1'b1;
        dif.iDirection = dir;
        dif.iBase_Address = base;
        dif.iLength = len;
        k = cyc;
        doneBase = doneCnt;
    endtask

    task automatic endStart();
        @(posedge clk);
        #1;
        dif.iStart = 1'b0;
    endtask

    task automatic sendStream(input logic [31:0] first, input logic [31:0] step, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            dif.iIn_Valid = 1'b1;
            dif.iIn_Data = first + step * 32'(i);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!dif.oIn_Ready && t < 50);
            if (!dif.oIn_Ready) check("in_ready_timeout", dif.oIn_Ready, 1);
            @(posedge clk);
            #1;
        end
        dif.iIn_Valid = 1'b0;
    endtask

    task automatic waitDone();
        int t = 0;
        while (doneCnt <= doneBase && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_seen", 64'(doneCnt > doneBase), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        dif.iStart = 1'b0;
        dif.iDirection = 1'b0;
        dif.iBase_Address = '0;
        dif.iLength = '0;
        dif.iIn_Valid = 1'b0;
        dif.iIn_Data = '0;
        #1 rstN = 1'b0;
        #1;
        check("rst_busy", dif.oBusy, 0);
        check("rst_done", dif.oDone, 0);
        check("rst_in_ready", dif.oIn_Ready, 0);
        check("rst_out_valid", dif.oOut_Valid, 0);
        check("rst_bus_valid", dif.oBus_Valid, 0);
        check("rst_bus_we", dif.oBus_Write_Enable, 0);
        check("rst_bus_addr", dif.oBus_Address, 0);
        check("rst_bus_wdata", dif.oBus_Write_Data, 0);
        check("rst_out_data", dif.oOut_Data, 0);
        @(posedge clk);
        #3 rstN = 1'b1;

        // WRITE base 0x10, 4 words, input valid held high.
        readyMode = 0;
        startXfer(1'b0, 32'h10, 16'd4, k);
        for (int i = 0; i < 4; i++) pushBus(32'h10 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i), k + 2 + i);
        doneQ.push_back(k + 6);
        endStart();
        sendStream(32'hA0, 32'h1, 4);
        waitDone();
        for (int i = 0; i < 4; i++) check("dmem_word", mem[4 + i], 32'hA0 + 32'(i));

        // READ base 0x10, 4 words, output always ready.
        startXfer(1'b1, 32'h10, 16'd4, k);
        for (int i = 0; i < 4; i++) begin
            pushBus(32'h10 + 32'(4 * i), 1'b0, 32'h0, k + 2 + i);
            pushOut(32'hA0 + 32'(i), k + 3 + i);
        end
        doneQ.push_back(k + 7);
        endStart();
        waitDone();

        // READ 8 words with ready toggling 1,0,0,1.
        readyMode = 1;
        startXfer(1'b1, 32'h10, 16'd8, k);
        for (int i = 0; i < 8; i++) begin
            pushBus(32'h10 + 32'(4 * i), 1'b0, 32'h0, -1);
            pushOut((i < 4) ? 32'hA0 + 32'(i) : 32'hC000_0004 + 32'(i), -1);
        end
        doneQ.push_back(-1);
        endStart();
        waitDone();
        readyMode = 0;

        // Zero length: done next cycle, no bus access.
        startXfer(1'b0, 32'h80, 16'd0, k);
        doneQ.push_back(k + 1);
        endStart();
        waitDone();

        // Start while busy is ignored.
        startXfer(1'b0, 32'h40, 16'd2, k);
        pushBus(32'h40, 1'b1, 32'h11, k + 2);
        pushBus(32'h44, 1'b1, 32'h22, k + 3);
        doneQ.push_back(k + 4);
        endStart();
        fork
            sendStream(32'h11, 32'h11, 2);
            begin
                @(posedge clk);
                #1;
                dif.iStart = 1'b1;
                dif.iDirection = 1'b1;
                dif.iBase_Address = 32'h100;
                dif.iLength = 16'd5;
                @(posedge clk);
                #1;
                dif.iStart = 1'b0;
            end
        join
        waitDone();
        check("dmem_busy_w0", mem[16], 32'h11);
        check("dmem_busy_w1", mem[17], 32'h22);

        // Address wrap at the top of the space.
        startXfer(1'b0, 32'hFFFF_FFFC, 16'd2, k);
        pushBus(32'hFFFF_FFFC, 1'b1, 32'h55, k + 2);
        pushBus(32'h0000_0000, 1'b1, 32'h66, k + 3);
        doneQ.push_back(k + 4);
        endStart();
        sendStream(32'h55, 32'h11, 2);
        waitDone();
        check("dmem_wrap_hi", mem[63], 32'h55);
        check("dmem_wrap_lo", mem[0], 32'h66);

        // Unaligned base is truncated to the word.
        startXfer(1'b1, 32'h13, 16'd1, k);
        pushBus(32'h10, 1'b0, 32'h0, k + 2);
        pushOut(32'hA0, k + 3);
        doneQ.push_back(k + 4);
        endStart();
        waitDone();

        // Reset in the middle of an 8-word READ.
        startXfer(1'b1, 32'h10, 16'd8, k);
        pushBus(32'h10, 1'b0, 32'h0, k + 2);
        pushBus(32'h14, 1'b0, 32'h0, k + 3);
        pushOut(32'hA0, k + 3);
        endStart();
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_bus_valid", dif.oBus_Valid, 1);
        check("pre_rst_out_valid", dif.oOut_Valid, 1);
        #1 rstN = 1'b0;
        #1;
        check("abort_bus_valid", dif.oBus_Valid, 0);
        check("abort_out_valid", dif.oOut_Valid, 0);
        check("abort_busy", dif.oBusy, 0);
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        repeat (2) @(posedge clk);
        startXfer(1'b1, 32'h18, 16'd2, k);
        pushBus(32'h18, 1'b0, 32'h0, k + 2);
        pushBus(32'h1C, 1'b0, 32'h0, k + 3);
        pushOut(32'hA2, k + 3);
        pushOut(32'hA3, k + 4);
        doneQ.push_back(k + 5);
        endStart();
        waitDone();

        repeat (3) @(posedge clk);
        check("busq_drained", 64'(busQ.size()), 0);
        check("outq_drained", 64'(outQ.size()), 0);
        check("doneq_drained", 64'(doneQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/cp_dmem_dma.md
Name: cp_dmem_dma

Overview:
- Word-streaming DMA engine that drives the bus port (port A) of the control-processor data memory.
- In WRITE mode it moves words from an input valid/ready stream into consecutive data-memory words.
- In READ mode it reads consecutive words and presents them on an output valid/ready stream with backpressure.
- Host logic or the array loader programs it with start/base/length and waits for a done pulse.

Parameters:
- DATA_WIDTH, `DEF_CP_DATA_WIDTH (32), word width of streams and memory.
- ADDR_WIDTH, `DEF_CP_D_MEM_ADDR_WIDTH, byte-address width of the memory bus port.
- LEN_WIDTH, 16, width of the transfer length in words.

Ports:
- iClk  in  1  system clock, positive-edge trigger
- iReset_N  in  1  reset
- iStart  in  1  start pulse, sampled only in IDLE
- iDirection  in  1  0 = stream->memory (WRITE), 1 = memory->stream (READ)
- iBase_Address  in  ADDR_WIDTH  byte address of first word; bits [1:0] ignored
- iLength  in  LEN_WIDTH  number of words to transfer
- oBusy  out  1  transfer in progress
- oDone  out  1  one-cycle completion pulse
- iIn_Valid  in  1  input stream valid
- iIn_Data  in  DATA_WIDTH  input stream data
- oIn_Ready  out  1  input stream ready
- oOut_Valid  out  1  output stream valid
- oOut_Data  out  DATA_WIDTH  output stream data
- iOut_Ready  in  1  output stream ready
- oBus_Valid  out  1  memory access valid
- oBus_Address  out  ADDR_WIDTH  memory byte address, always word-aligned
- oBus_Write_Data  out  DATA_WIDTH  memory write data
- oBus_Write_Enable  out  1  memory write enable
- iBus_Read_Data  in  DATA_WIDTH  memory read data, valid the cycle after a read access

Behaviour:
- Clock and reset: one clock, iClk. Reset iReset_N is asynchronous and active-low.
- Reset state: FSM = IDLE. oBusy, oDone, oIn_Ready, oOut_Valid, oBus_Valid and oBus_Write_Enable are 0. oBus_Address, oBus_Write_Data and oOut_Data are 0. Counters and FIFO are empty.
- Reset asserted mid-transfer aborts immediately: the bus strobes drop asynchronously, and no oDone is produced.
- All oBus_* outputs are registered. The memory has 1-cycle read latency.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE -> WRITE/READ on iStart with iLength != 0. This latches the address as {iBase_Address[ADDR_WIDTH-1:2], 2'b00} and remaining = iLength. oBusy rises the next cycle.
- IDLE with iStart and iLength == 0 -> DONE with no bus access.
- iStart in any state other than IDLE is ignored.
- WRITE:
  - oIn_Ready = 1 while remaining > 0.
  - On an input handshake in cycle t, cycle t+1 has oBus_Valid = oBus_Write_Enable = 1, oBus_Write_Data = iIn_Data and oBus_Address = current address. The handshake also increments the address by 4 and decrements remaining.
  - Throughput is 1 word/cycle.
  - The cycle after the last bus write, FSM -> DONE.
- READ:
  - Issue a read (oBus_Valid = 1, oBus_Write_Enable = 0) when remaining > 0 and (FIFO occupancy + reads in flight) < 2.
  - Returned data is pushed into a 2-entry output FIFO the cycle after issue.
  - oOut_Valid = FIFO not empty. oOut_Data = FIFO head.
  - Sustains 1 word/cycle while iOut_Ready = 1. Never drops or duplicates a word under any iOut_Ready pattern.
  - After the final output handshake (remaining = 0, FIFO empty, no read in flight), FSM -> DONE.
- DONE: lasts one cycle with oDone = 1 and oBusy = 0, then returns to IDLE. A new iStart is accepted in the cycle after DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH, so it wraps from all-ones word to 0. Only word addresses are ever emitted.
- Stream data is ignored outside WRITE. oOut_Valid is never asserted outside READ.

Test Plan:
- WRITE, base 0x10, len 4, iIn_Valid held high with data 0xA0..0xA3 -> bus writes to 0x10, 0x14, 0x18, 0x1C on 4 consecutive cycles; oDone pulses once; dmem words 4..7 read back 0xA0..0xA3.
- READ, base 0x10, len 4, iOut_Ready = 1 -> oOut_Data 0xA0..0xA3 on 4 consecutive cycles; oDone one cycle after the last handshake.
- READ len 8 with iOut_Ready toggling 1,0,0,1,… -> all 8 words delivered in order with none lost or duplicated; never more than 2 reads outstanding plus buffered.
- iLength = 0 -> no oBus_Valid; oDone pulses the cycle after the start cycle. iStart while busy -> ignored, and the first transfer completes unchanged.
- Base 0xFFFF_FFFC (ADDR_WIDTH = 32), len 2 -> addresses 0xFFFF_FFFC then 0x0000_0000. Base 0x13 -> first address 0x10.
- iReset_N low in the middle of a len-8 READ -> oBus_Valid and oOut_Valid drop immediately with no oDone; a subsequent new transfer completes normally.
